// File: rtl/multiple_of_3or5_gen.sv
// ---------------------------------------------------------------------------
// multiple_of_3or5_gen
//
// Walks the 6-bit range 0..63 in ascending order and emits every value that
// is a multiple of 3 and/or 5 (chosen by sel when start is accepted). Each
// value carries its divisibility tags and is handed out over valid/ready.
// Divisibility is tracked with running residues, so no divider is needed.
//
// Ports:
//   clk            clock, rising edge
//   rst_n          asynchronous active-low reset
//   start          begin a scan (honoured only when idle)
//   sel[1:0]       00: x15, 01: x3, 10: x5, 11: x3 or x5
//   ready          consumer accepts the current value
//   N5..N0         emitted value, N5 is the MSB
//   M3, M5         value is divisible by 3 / by 5
//   valid          N5..N0, M3, M5 are meaningful
//   busy           scan in progress
//   done           one-cycle pulse at the end of a scan
//   count[4:0]     accepted transfers since the last start
//
// Build option: define MULT_GEN_COUNT_EN to implement the transfer counter;
// otherwise count is tied to zero and no counter register exists.
// ---------------------------------------------------------------------------
module multiple_of_3or5_gen (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] sel,
    input  logic       ready,
    output logic       N5,
    output logic       N4,
    output logic       N3,
    output logic       N2,
    output logic       N1,
    output logic       N0,
    output logic       M3,
    output logic       M5,
    output logic       valid,
    output logic       busy,
    output logic       done,
    output logic [4:0] count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t     state_q;
    logic [5:0] cur_q;
    logic [1:0] r3_q;
    logic [2:0] r5_q;
    logic [1:0] mode_q;
    logic [5:0] val_q;
    logic       m3_q;
    logic       m5_q;
    logic       valid_q;
    logic       busy_q;
    logic       done_q;

    logic [5:0] cur_d;
    logic [1:0] r3_d;
    logic [2:0] r5_d;
    logic       r3_zero;
    logic       r5_zero;
    logic       match;

    // Successor of cur and its residues. cur_d wraps at 63, but the FSM never
    // advances from 63, so the wrapped value is never loaded.
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cur_d   = cur_q + 6'd1;
        r3_d    = (r3_q == 2'd2) ? 2'd0 : r3_q + 2'd1;
        r5_d    = (r5_q == 3'd4) ? 3'd0 : r5_q + 3'd1;
        r3_zero = (r3_q == 2'd0);
        r5_zero = (r5_q == 3'd0);
        match   = 1'b0;
        case (mode_q)
            2'b00: match = r3_zero && r5_zero;
            2'b01: match = r3_zero;
            2'b10: match = r5_zero;
            2'b11: match = r3_zero || r5_zero;
            default: match = 1'b0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    // NOTE: every register here is a plain flop (no memory arrays), so all of
    // them are reset; a mid-scan reset discards the in-flight value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cur_q   <= 6'd0;
            r3_q    <= 2'd0;
            r5_q    <= 3'd0;
            mode_q  <= 2'd0;
            val_q   <= 6'd0;
            m3_q    <= 1'b0;
            m5_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mode_q  <= sel;
                        cur_q   <= 6'd0;
                        r3_q    <= 2'd0;
                        r5_q    <= 3'd0;
                        busy_q  <= 1'b1;
                        state_q <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (match) begin
                        val_q   <= cur_q;
                        m3_q    <= r3_zero;
                        m5_q    <= r5_zero;
                        valid_q <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (cur_q == 6'd63) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cur_q <= cur_d;
                        r3_q  <= r3_d;
                        r5_q  <= r5_d;
                    end
                end
                ST_HOLD: begin
                    // valid is always 1 here, so ready alone completes the transfer.
                    if (ready) begin
                        valid_q <= 1'b0;
                        if (cur_q == 6'd63) begin
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            state_q <= ST_DONE;
                        end else begin
                            cur_q   <= cur_d;
                            r3_q    <= r3_d;
                            r5_q    <= r5_d;
                            state_q <= ST_SCAN;
                        end
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

`ifdef MULT_GEN_COUNT_EN
    logic [4:0] count_q;

    // Counts accepted transfers; holds through DONE/IDLE until the next start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 5'd0;
        end else if (state_q == ST_IDLE && start) begin
            count_q <= 5'd0;
        end else if (state_q == ST_HOLD && ready) begin
            count_q <= count_q + 5'd1;
        end
    end

    assign count = count_q;
`else
    assign count = 5'd0;
`endif

    assign {N5, N4, N3, N2, N1, N0} = val_q;
    assign M3    = m3_q;
    assign M5    = m5_q;
    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: doc/multiple_of_3or5_gen.md
# multiple_of_3or5_gen

- Sequential generator that walks the 6-bit range 0..63 and emits, in ascending order, every value that is a multiple of 3 and/or 5, as selected by a mode input.
- Each emitted value is tagged with its M3/M5 divisibility flags.
- Values are delivered one at a time over a valid/ready handshake, on the same six-bit N5..N0 bus used by the divisibility-check logic, so it can act as a stimulus source for that logic.

## Interface
- No parameters; width is fixed at 6 bits.
- `clk`  input  1  sole clock; all state updates on the rising edge.
- `rst_n`  input  1  reset; asynchronous, active-low.
- `start`  input  1  begins a scan; honored only in IDLE.
- `sel`  input  2  mode, sampled when start is accepted:
  - 00 = multiples of 15 (3 AND 5)
  - 01 = multiples of 3
  - 10 = multiples of 5
  - 11 = multiples of 3 OR 5
- `ready`  input  1  consumer accepts the current value.
- `N5..N0`  output  1 each  emitted value; N5 is the MSB.
- `M3`, `M5`  output  1 each  divisibility tags of the emitted value.
- `valid`  output  1  N5..N0, M3 and M5 are meaningful.
- `busy`  output  1  high in SCAN and HOLD.
- `done`  output  1  one-cycle pulse when a scan completes.
- `count`  output  5  number of accepted values since the last start (see Configuration).

## Operation
- State machine states: IDLE, SCAN, HOLD, DONE.
- Internal registers:
  - `cur` (6 bits)
  - `r3` (0..2) and `r5` (0..4): running residues of `cur`. They are incremented in lockstep with `cur` and wrap 2→0 and 4→0. No divide or modulo hardware is used.
  - `mode`: latched copy of `sel`.
- IDLE:
  - On start=1, latch `mode`, clear `cur`, `r3`, `r5` and `count`, then go to SCAN.
  - If start=0, stay in IDLE.
- SCAN, each cycle, evaluate `cur`:
  - match = (`r3`==0 && `r5`==0) for 00, (`r3`==0) for 01, (`r5`==0) for 10, (`r3`==0 || `r5`==0) for 11.
  - On a match, register N5..N0 ← `cur`, M3 ← (`r3`==0), M5 ← (`r5`==0), set valid ← 1, and go to HOLD.
  - On no match with `cur`==63, go to DONE.
  - On no match otherwise, increment `cur`, `r3` and `r5`.
- HOLD:
  - Outputs are held stable while valid=1 and ready=0.
  - On valid && ready: set valid ← 0 and increment `count`. Then go to DONE if `cur`==63; otherwise increment `cur`, `r3`, `r5` and return to SCAN.
- DONE: assert done for exactly one cycle, then go to IDLE.
- `cur` never wraps past 63; the scan always terminates at 63.
- start is ignored in SCAN, HOLD and DONE; `sel` changes after start is accepted have no effect.
- Reset, including mid-scan, forces:
  - state = IDLE
  - valid, busy, done = 0
  - N5..N0, M3, M5 = 0
  - `count` = 0
  - `cur`, `r3`, `r5` = 0
- Any in-flight value is discarded on reset.

## Timing
- All outputs are registered; none depends combinationally on inputs.
- start sampled at edge k → busy=1 after edge k.
- Value 0 always matches, so the first valid=1 appears after edge k+1.
- Each non-matching value costs 1 SCAN cycle.
- Each match costs 1 SCAN cycle plus at least 1 HOLD cycle. With ready held at 1, a match is accepted at the first HOLD edge.
- done is high for the cycle after the final transfer or final SCAN; busy=0 in that cycle. IDLE follows, and start is accepted on the next edge.
- Expected totals per mode: 01 = 22 values, 10 = 13 values, 11 = 30 values, 00 = 5 values.

## Configuration
- `MULT_GEN_COUNT_EN` defined: `count` is implemented as a 5-bit saturating-free accepted-transfer counter. It is cleared on start and on reset, and holds its value through DONE and IDLE until the next start.
- `MULT_GEN_COUNT_EN` undefined: the `count` port remains present but is tied to 0; no counter register is built.

## Test plan
- sel=01, ready=1:
  - Output is 0,3,6,…,63 (22 values), each with M3=1; M5=1 only for 0, 15, 30, 45, 60.
  - done pulses once after 63; `count`=22 when the macro is defined.
- sel=00, ready=1: output is exactly 0,15,30,45,60, all with M3=M5=1; then done.
- sel=11 with ready toggling 1-cycle-on/2-off:
  - 30 values in ascending order.
  - N5..N0, M3 and M5 are stable whenever valid=1 and ready=0.
  - Every emitted value satisfies M3==(v%3==0) and M5==(v%5==0).
- sel=10, start asserted again and sel changed to 01 mid-scan: both are ignored; output is 0,5,…,60 (13 values); then done.
- Reset asserted while in HOLD on value 20 (sel=10):
  - All outputs are 0 immediately (asynchronously).
  - After release and start with sel=01, output restarts at 0.
- Reset held low with start=1: valid, busy and done stay 0; no value is emitted.
